// File: rtl/apb_slave_mem_pkg.sv
// Shared sizes, FSM state encoding and wait-counter type for the APB
// register-memory target.
package apb_slave_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_e;

  typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/apb_slave_mem_array.sv
// 256x32 register storage: one synchronous write port, one combinational
// read port, asynchronous active-low clear of every word.
module apb_slave_mem_array
  import apb_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB target over a 256x32 register memory with a programmable number of
// wait states per transfer for reads and for writes.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata
);

  localparam wait_cnt_t N_RD = wait_cnt_t'(WAIT_RD);
  localparam wait_cnt_t N_WR = wait_cnt_t'(WAIT_WR);

  apb_slv_state_e    state_q, state_d;
  wait_cnt_t         cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  wait_cnt_t         wait_n;

  assign wait_n  = pwrite ? N_WR : N_RD;
  // With zero wait states READY is entered straight from setup, so the read
  // port must see the address being latched rather than the stale one.
  assign rd_addr = (state_q == IDLE) ? paddr : addr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = pready_q;
    prdata_d = prdata_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        pready_d = 1'b0;
        prdata_d = '0;
        if (psel && !penable) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          if (wait_n == '0) begin
            state_d  = READY;
            pready_d = 1'b1;
            prdata_d = pwrite ? '0 : rd_data;
          end else begin
            cnt_d   = wait_n;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = READY;
            pready_d = 1'b1;
            prdata_d = wr_q ? '0 : rd_data;
          end
        end
      end
      READY: begin
        if (!psel) begin
          state_d  = IDLE;
          pready_d = 1'b0;
          prdata_d = '0;
        end else if (penable) begin
          mem_we   = wr_q;
          state_d  = IDLE;
          pready_d = 1'b0;
          prdata_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        pready_d = 1'b0;
        prdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  // Transfer latches carry no reset: they are only consumed after a setup.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  apb_slave_mem_array u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign pready = pready_q;
  assign prdata = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed and randomized APB transfers against two targets (default wait
// states and zero wait states) checked against an array memory model.
module tb_apb_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  psel, penable, pwrite, pready;
  logic [7:0]  paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];

  logic [31:0] model [2][256];
  int          n_rd  [2];
  int          n_wr  [2];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_RD(2), .WAIT_WR(1)) dut (
    .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]),
    .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0])
  );

  apb_slave_mem #(.WAIT_RD(0), .WAIT_WR(0)) dut0 (
    .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]),
    .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) model[d][a] = 32'h0;
  endtask

  // Called and returns at 1 time unit after a rising edge. With corrupt set,
  // address, data and direction are disturbed after setup.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input bit corrupt);
    int cycles;
    int n;
    n = wr ? n_wr[d] : n_rd[d];
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    if (corrupt) begin
      paddr[d]  = a ^ 8'h30;
      pwdata[d] = ~wd;
      pwrite[d] = ~wr;
    end
    cycles = 0;
    while (!pready[d] && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk(wr ? "wr_latency" : "rd_latency", 32'(cycles), 32'(n));
    chk("prdata_ready", prdata[d], wr ? 32'h0 : model[d][a]);
    @(posedge clk); #1;
    if (wr) model[d][a] = wd;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("pready_one_cycle", {31'h0, pready[d]}, 32'h0);
    chk("prdata_after", prdata[d], 32'h0);
  endtask

  initial begin
    n_rd[0] = 2; n_wr[0] = 1;
    n_rd[1] = 0; n_wr[1] = 0;
    clear_model();
    reset = 1'b0;
    psel = '0; penable = '0; pwrite = '0;
    for (int d = 0; d < 2; d++) begin paddr[d] = '0; pwdata[d] = '0; end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", {31'h0, pready[d]}, 32'h0);
      chk("reset_prdata", prdata[d], 32'h0);
    end
    reset = 1'b1;

    xfer(0, 1'b0, 8'h00, 32'h0, 1'b0);
    xfer(0, 1'b1, 8'h3C, 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b0, 8'h3C, 32'h0, 1'b0);
    chk("b2b_model", model[0][8'h3C], 32'hDEADBEEF);

    // Enable without setup is ignored.
    penable[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("enable_no_setup", {31'h0, pready[0]}, 32'h0);
    end
    penable[0] = 1'b0;

    for (int a = 0; a < 256; a++) begin
      xfer(1, 1'b1, 8'(a), 32'(a) * 32'h01010101, 1'b0);
      xfer(1, 1'b0, 8'(a), 32'h0, 1'b0);
    end

    // Abort a write to 0x10 while it waits.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h10; pwdata[0] = 32'h12345678;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_pready", {31'h0, pready[0]}, 32'h0);
    end
    xfer(0, 1'b0, 8'h10, 32'h0, 1'b0);
    chk("abort_model", model[0][8'h10], 32'h0);

    xfer(0, 1'b1, 8'h10, 32'hCAFE0010, 1'b1);
    xfer(0, 1'b0, 8'h10, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h20, 32'h0, 1'b0);
    xfer(1, 1'b1, 8'h10, 32'h0BAD0010, 1'b1);
    xfer(1, 1'b0, 8'h20, 32'h0, 1'b0);
    xfer(1, 1'b0, 8'h10, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int d;
      d = int'($urandom_range(1, 0));
      xfer(d, 1'($urandom), 8'($urandom_range(7, 0)) + 8'h40, $urandom, 1'($urandom_range(3, 0) == 0));
    end

    // Reset lands while a read of 0x01 is presenting data.
    xfer(0, 1'b1, 8'h01, 32'hA5A5A5A5, 1'b0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h01;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_reset_pready", {31'h0, pready[0]}, 32'h1);
    chk("pre_reset_prdata", prdata[0], 32'hA5A5A5A5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_pready", {31'h0, pready[0]}, 32'h0);
    chk("async_prdata", prdata[0], 32'h0);
    psel = '0; penable = '0;
    clear_model();
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(0, 1'b0, 8'h01, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h3C, 32'h0, 1'b0);
    xfer(1, 1'b0, 8'hFF, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB target that terminates the bus driven through the APB testbench interface (8-bit `paddr`, 32-bit data). It holds a 256×32 register memory. It inserts a parameterised number of wait states per transfer using `pready`. It returns read data on `prdata`. It sits directly downstream of the APB master driver and is the DUT observed by the APB monitor.

## Interface
Parameters:
- `WAIT_RD`, default 2: wait cycles inserted before `pready` on reads, range 0..15.
- `WAIT_WR`, default 1: wait cycles inserted before `pready` on writes, range 0..15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `psel`, input, 1: slave select.
- `penable`, input, 1: access phase marker.
- `paddr`, input, 8: word address, 256 locations.
- `pwrite`, input, 1: 1 selects write, 0 selects read.
- `pwdata`, input, 32: write data.
- `pready`, output, 1: transfer-complete handshake, registered.
- `prdata`, output, 32: read data, registered.

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE
  - Setup detect (`psel`=1, `penable`=0) latches `paddr`, `pwrite` and `pwdata`.
  - The wait load is N = `pwrite` ? `WAIT_WR` : `WAIT_RD`.
  - If N = 0, go to READY. Otherwise load the counter with N and go to WAIT.
  - `penable`=1 without a preceding setup is ignored: stay in IDLE, `pready` stays 0.
- WAIT
  - While `psel`&`penable`, the counter decrements each edge.
  - When the counter reaches 0, go to READY.
- READY
  - `pready`=1.
  - On a read, `prdata` = mem[latched addr], loaded on the edge entering READY.
  - On the next edge with `psel`&`penable`:
    - Write: mem[latched addr] ← latched `pwdata`.
    - Then `pready`→0, `prdata`→0, go to IDLE.
- Abort: `psel`=0 sampled in WAIT or READY returns the FSM to IDLE, performs no memory write, and clears `pready`/`prdata` to 0.
- The latched address, direction and data are used for the whole transfer. Changes on the bus after setup are ignored.
- `prdata` is 0 whenever `pready`=0 or the transfer is a write.
- Counter width is 4 bits. Decrement never underflows because WAIT exits at 0.

## Timing
- Reset (async assert, `reset`=0):
  - FSM goes to IDLE, counter to 0, `pready` to 0, `prdata` to 0.
  - All 256 memory words go to 0.
  - Deassertion is honoured on the next rising edge.
- Reset asserted mid-transfer: the transfer is lost and no write is committed.
- Latency: setup sampled at edge E gives `pready`=1 from edge E+N (N=0 gives `pready` high for the first access cycle).
- Total transfer is N+2 cycles including setup.
- `pready` is high for exactly one cycle per completed transfer.
- Back-to-back transfers: a setup in the cycle after completion is sampled by IDLE with no bubble.
- A read immediately following a write to the same address returns the new data.

## Structure
- Package `apb_slave_pkg` holds:
  - `ADDR_W`=8, `DATA_W`=32, `DEPTH`=256.
  - The `apb_slv_state_e` enum {IDLE, WAIT, READY}.
  - The wait-count typedef, 4 bits.
- Sub-module `apb_slave_mem_array`: 256×32 storage with one sync write port, one async read port and async active-low clear. The top level holds the FSM, counter and latches.

## Test plan
- Reset then read 0x00 with `WAIT_RD`=2 → `pready` high 2 cycles after setup, `prdata`=0x00000000.
- Write 0xDEADBEEF to 0x3C, then read 0x3C → write `pready` after `WAIT_WR` cycles, read returns 0xDEADBEEF with no idle cycles between transfers.
- `WAIT_RD`=`WAIT_WR`=0, alternating writes/reads 0x00..0xFF with data = addr×0x01010101 → every transfer is 2 cycles and all readbacks match.
- Write 0x12345678 to 0x10, drop `psel` in WAIT → FSM returns to IDLE, `pready` never high, and a read of 0x10 returns 0.
- Change `paddr` to 0x20 during access of a write to 0x10 → data lands at 0x10 and 0x20 is unchanged.
- Write 0xA5A5A5A5 to 0x01, assert `reset` mid-read of 0x01 → `pready`/`prdata` go to 0 immediately, and after deassertion a read of 0x01 returns 0.
